// File: rtl/rect_overlay_ctrl.sv
// Rectangle overlay controller: double-buffered rectangle descriptor tables fed by two
// round-robin write requesters, and a 2-stage pixel-address hit lookup.
module rect_overlay_ctrl #(
    parameter int NUM_RECT  = 4,
    parameter int RECT_ROWS = 30,
    parameter int LINE_W    = 640
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr0_req,
    input  logic [1:0]  wr0_idx,
    input  logic [18:0] wr0_start,
    input  logic [9:0]  wr0_width,
    input  logic [7:0]  wr0_color,
    output logic        wr0_ack,
    input  logic        wr1_req,
    input  logic [1:0]  wr1_idx,
    input  logic [18:0] wr1_start,
    input  logic [9:0]  wr1_width,
    input  logic [7:0]  wr1_color,
    output logic        wr1_ack,
    input  logic        frame_end,
    input  logic        addr_valid,
    input  logic [18:0] addr,
    output logic        hit_valid,
    output logic        hit,
    output logic [1:0]  hit_idx,
    output logic [7:0]  hit_color
);
    // A width wider than one line can reach the pixel row below, so one offset may
    // correspond to several (row, column) pairs; NWRAP bounds the extra rows to try.
    localparam int          NWRAP = 1022 / LINE_W;
    localparam logic [18:0] LW19  = 19'(LINE_W);

    logic [18:0]         r_sh_start  [NUM_RECT];
    logic [9:0]          r_sh_width  [NUM_RECT];
    logic [7:0]          r_sh_color  [NUM_RECT];
    logic [18:0]         r_act_start [NUM_RECT];
    logic [9:0]          r_act_width [NUM_RECT];
    logic [7:0]          r_act_color [NUM_RECT];
    logic [NUM_RECT-1:0] r_dirty;

    logic r_ack0, r_ack1;
    logic r_last1;                                  // requester 1 was granted most recently

    logic                r_s1_valid;
    logic [NUM_RECT-1:0] r_s1_hit;
    logic [7:0]          r_s1_color [NUM_RECT];
    logic                r_s2_valid, r_s2_hit;
    logic [1:0]          r_s2_idx;
    logic [7:0]          r_s2_color;

    logic        w_el0, w_el1, w_gnt0, w_gnt1, w_we;
    logic [1:0]  w_widx;
    logic [18:0] w_wstart;
    logic [9:0]  w_wwidth;
    logic [7:0]  w_wcolor;

    assign w_el0    = wr0_req & ~r_ack0;
    assign w_el1    = wr1_req & ~r_ack1;
    assign w_gnt0   = w_el0 & (~w_el1 | r_last1);
    assign w_gnt1   = w_el1 & (~w_el0 | ~r_last1);
    assign w_we     = w_gnt0 | w_gnt1;
    assign w_widx   = w_gnt0 ? wr0_idx   : wr1_idx;
    assign w_wstart = w_gnt0 ? wr0_start : wr1_start;
    assign w_wwidth = w_gnt0 ? wr0_width : wr1_width;
    assign w_wcolor = w_gnt0 ? wr0_color : wr1_color;

    logic [18:0]         w_off [NUM_RECT];
    logic [18:0]         w_q   [NUM_RECT];
    logic [18:0]         w_rem [NUM_RECT];
    logic [NUM_RECT-1:0] w_hit;

    // Underflowing row candidates land above 2^19 in 20 bits and fail the row compare.
    always_comb begin
        for (int k = 0; k < NUM_RECT; k++) begin
            w_off[k] = addr - r_act_start[k];
            w_q[k]   = w_off[k] / LW19;
            w_rem[k] = w_off[k] % LW19;
            w_hit[k] = 1'b0;
            for (int j = 0; j <= NWRAP; j++) begin
                if ((({1'b0, w_q[k]} - 20'(j)) < 20'(RECT_ROWS)) &&
                    ((w_rem[k] + 19'(j * LINE_W)) < {9'd0, r_act_width[k]}))
                    w_hit[k] = 1'b1;
            end
            if (addr < r_act_start[k] || r_act_width[k] == 10'd0)
                w_hit[k] = 1'b0;
        end
    end

    logic       w_p_hit;
    logic [1:0] w_p_idx;
    logic [7:0] w_p_color;

    always_comb begin
        w_p_hit   = 1'b0;
        w_p_idx   = 2'd0;
        w_p_color = 8'd0;
        for (int k = NUM_RECT - 1; k >= 0; k--) begin
            if (r_s1_hit[k]) begin
                w_p_hit   = 1'b1;
                w_p_idx   = 2'(k);
                w_p_color = r_s1_color[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_RECT; k++) begin
                r_sh_start[k]  <= '0;
                r_sh_width[k]  <= '0;
                r_sh_color[k]  <= '0;
                r_act_start[k] <= '0;
                r_act_width[k] <= '0;
                r_act_color[k] <= '0;
                r_s1_color[k]  <= '0;
            end
            r_dirty    <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_last1    <= 1'b1;
            r_s1_valid <= 1'b0;
            r_s1_hit   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_hit   <= 1'b0;
            r_s2_idx   <= '0;
            r_s2_color <= '0;
        end else begin
            r_ack0 <= w_gnt0;
            r_ack1 <= w_gnt1;
            if (w_we)
                r_last1 <= w_gnt1;
            if (frame_end) begin
                for (int k = 0; k < NUM_RECT; k++) begin
                    if (r_dirty[k]) begin
                        r_act_start[k] <= r_sh_start[k];
                        r_act_width[k] <= r_sh_width[k];
                        r_act_color[k] <= r_sh_color[k];
                    end
                end
                r_dirty <= '0;
            end
            // A write in the commit cycle re-marks its slot after the clear above.
            if (w_we) begin
                r_sh_start[w_widx] <= w_wstart;
                r_sh_width[w_widx] <= w_wwidth;
                r_sh_color[w_widx] <= w_wcolor;
                r_dirty[w_widx]    <= 1'b1;
            end
            r_s1_valid <= addr_valid;
            r_s1_hit   <= w_hit;
            for (int k = 0; k < NUM_RECT; k++)
                r_s1_color[k] <= r_act_color[k];
            r_s2_valid <= r_s1_valid;
            r_s2_hit   <= w_p_hit;
            r_s2_idx   <= w_p_idx;
            r_s2_color <= w_p_color;
        end
    end

    assign wr0_ack   = r_ack0;
    assign wr1_ack   = r_ack1;
    assign hit_valid = r_s2_valid;
    assign hit       = r_s2_hit;
    assign hit_idx   = r_s2_idx;
    assign hit_color = r_s2_color;
endmodule
